// File: rtl/cond_status_if.sv
// cond_status_if: bundles the ID-stage condition/status signals of cond_status_unit.
//   master : issue stage / EXE side; drives flag writeback, flush and the issue group
//            and observes check/stall/status/pending.
//   slave  : cond_status_unit.
// Handshake: an issue group is presented with issue_valid; stall acts as an active-low
// ready. The group is accepted in a cycle where stall=0 and flush=0, and it must be
// held stable by the upstream stage while stall=1.
interface cond_status_if #(
  parameter int LANES      = 1,
  parameter int PIPE_DEPTH = 2,
  parameter int CW         = $clog2(LANES*PIPE_DEPTH+1)
);
  logic                 flag_wr_en;
  logic [3:0]           flag_in;
  logic                 flush;
  logic [LANES-1:0]     issue_valid;
  logic [4*LANES-1:0]   issue_cond;
  logic [LANES-1:0]     issue_sets_flags;
  logic [LANES-1:0]     check;
  logic                 stall;
  logic [3:0]           status;
  logic [CW-1:0]        pending;

  modport master (
    output flag_wr_en, flag_in, flush, issue_valid, issue_cond, issue_sets_flags,
    input  check, stall, status, pending
  );

  modport slave (
    input  flag_wr_en, flag_in, flush, issue_valid, issue_cond, issue_sets_flags,
    output check, stall, status, pending
  );
endinterface

// File: rtl/cond_status_unit.sv
// cond_status_unit: holds the NZCV status register, evaluates the condition field of
// up to LANES instructions per cycle (lane 0 oldest) and stalls a group that would
// read stale flags while flag-setters are still in flight.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset
//   bus  : cond_status_if.slave (flag writeback, flush, issue group, check/stall/
//          status/pending)
// Optional feature: define COND_NV_EN to make cond 1111 "never" (evaluates 0 and
// needs flags); otherwise 1111 behaves exactly like 1110 (always).
module cond_status_unit #(
  parameter int LANES      = 1,
  parameter int PIPE_DEPTH = 2,
  parameter int CW         = $clog2(LANES*PIPE_DEPTH+1)
) (
  input logic          clk,
  input logic          rst,
  cond_status_if.slave bus
);
  localparam int          MAX_PEND = LANES*PIPE_DEPTH;
  localparam logic [CW:0] MAX_W    = (CW+1)'(MAX_PEND);

  logic [3:0]       status_q, status_d;
  logic [CW-1:0]    pending_q, pending_d;

  logic [3:0]       eff;
  logic [CW-1:0]    pend_eff;
  logic [CW:0]      accepted;
  logic [CW:0]      sum;
  logic [LANES-1:0] check_c;
  logic             stall_raw;
  logic             stall_c;
  logic             older_setter;
  logic             needs_flags;
  logic [3:0]       cond_i;

  function automatic logic cond_eval(input logic [3:0] code, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (code)
      4'h0:    cond_eval = z;
      4'h1:    cond_eval = ~z;
      4'h2:    cond_eval = c;
      4'h3:    cond_eval = ~c;
      4'h4:    cond_eval = n;
      4'h5:    cond_eval = ~n;
      4'h6:    cond_eval = v;
      4'h7:    cond_eval = ~v;
      4'h8:    cond_eval = c & ~z;
      4'h9:    cond_eval = ~c | z;
      4'ha:    cond_eval = (n == v);
      4'hb:    cond_eval = (n != v);
      4'hc:    cond_eval = ~z & (n == v);
      4'hd:    cond_eval = z | (n != v);
      4'he:    cond_eval = 1'b1;
`ifdef COND_NV_EN
      default: cond_eval = 1'b0;
`else
      default: cond_eval = 1'b1;
`endif
    endcase
  endfunction

  always_comb begin
    // Same-cycle EXE writeback is bypassed so a dependent lane need not wait for it.
    eff          = bus.flag_wr_en ? bus.flag_in : status_q;
    // A writeback retires one in-flight setter; a spurious write (counter 0) retires none.
    pend_eff     = pending_q - CW'(bus.flag_wr_en && (pending_q != '0));
    check_c      = '0;
    stall_raw    = 1'b0;
    older_setter = 1'b0;
    accepted     = '0;
    needs_flags  = 1'b0;
    cond_i       = 4'h0;
    for (int i = 0; i < LANES; i++) begin
      cond_i      = bus.issue_cond[4*i +: 4];
      check_c[i]  = bus.issue_valid[i] & cond_eval(cond_i, eff);
`ifdef COND_NV_EN
      needs_flags = bus.issue_valid[i] && (cond_i != 4'he);
`else
      needs_flags = bus.issue_valid[i] && (cond_i != 4'he) && (cond_i != 4'hf);
`endif
      // An older setter in the same group has not produced its flags yet.
      stall_raw    = stall_raw | (needs_flags && ((pend_eff != '0) || older_setter));
      older_setter = older_setter | (bus.issue_valid[i] & bus.issue_sets_flags[i]);
      accepted     = accepted + (CW+1)'(bus.issue_valid[i] & bus.issue_sets_flags[i]);
    end
    stall_c = stall_raw & ~bus.flush;
    sum     = {1'b0, pend_eff} + ((stall_c || bus.flush) ? '0 : accepted);
    if (bus.flush) begin
      pending_d = '0;
    end else if (sum > MAX_W) begin
      pending_d = MAX_W[CW-1:0];
    end else begin
      pending_d = sum[CW-1:0];
    end
    // Writeback lands even in a flush cycle: the writing instruction is older than the flush.
    status_d = bus.flag_wr_en ? bus.flag_in : status_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q  <= 4'b0000;
      pending_q <= '0;
    end else begin
      status_q  <= status_d;
      pending_q <= pending_d;
    end
  end

  assign bus.check   = check_c;
  assign bus.stall   = stall_c;
  assign bus.status  = status_q;
  assign bus.pending = pending_q;
endmodule

// File: tb/tb_cond_status_unit.sv
// tb_cond_status_unit: directed scenarios, an exhaustive condition/flag sweep and
// randomized traffic for cond_status_unit with LANES=2, PIPE_DEPTH=2.
module tb_cond_status_unit;
  localparam int LANES = 2;
  localparam int PD    = 2;
  localparam int CW    = $clog2(LANES*PD+1);
  localparam int MAXP  = LANES*PD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cond_status_if #(.LANES(LANES), .PIPE_DEPTH(PD)) bus();

  cond_status_unit #(.LANES(LANES), .PIPE_DEPTH(PD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_checks = 0;
  int   n_errs   = 0;
  bit   chk_en   = 1'b0;

  // Reference state: architectural flags and number of outstanding setters.
  logic [3:0] m_status  = 4'h0;
  int         m_pending = 0;

  function automatic bit cond_ok(input logic [3:0] code, input logic [3:0] f);
    bit n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (int'(code))
      0:  return z;
      1:  return !z;
      2:  return c;
      3:  return !c;
      4:  return n;
      5:  return !n;
      6:  return v;
      7:  return !v;
      8:  return c && !z;
      9:  return !c || z;
      10: return n == v;
      11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      14: return 1'b1;
`ifdef COND_NV_EN
      default: return 1'b0;
`else
      default: return 1'b1;
`endif
    endcase
  endfunction

  function automatic bit uses_flags(input logic [3:0] code);
`ifdef COND_NV_EN
    return code != 4'he;
`else
    return code < 4'he;
`endif
  endfunction

  // Expected outputs for the current inputs and reference state.
  task automatic model_eval(output int exp_chk, output bit exp_stall, output int n_set,
                            output int pend_after_wb);
    logic [3:0] flags;
    bit         setter_ahead;
    logic [3:0] code;
    flags         = bus.flag_wr_en ? bus.flag_in : m_status;
    pend_after_wb = (bus.flag_wr_en && m_pending > 0) ? m_pending - 1 : m_pending;
    exp_chk       = 0;
    exp_stall     = 1'b0;
    n_set         = 0;
    setter_ahead  = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      code = bus.issue_cond[4*i +: 4];
      if (bus.issue_valid[i]) begin
        if (cond_ok(code, flags)) exp_chk += (1 << i);
        if (uses_flags(code) && (pend_after_wb > 0 || setter_ahead)) exp_stall = 1'b1;
        if (bus.issue_sets_flags[i]) begin
          setter_ahead = 1'b1;
          n_set++;
        end
      end
    end
    if (bus.flush) exp_stall = 1'b0;
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference state update on each rising edge.
  always @(posedge clk) begin
    int  ec, pa, ns, nxt;
    bit  es;
    if (rst) begin
      m_status  <= 4'h0;
      m_pending <= 0;
    end else begin
      model_eval(ec, es, ns, pa);
      if (bus.flush) nxt = 0;
      else           nxt = pa + ((es) ? 0 : ns);
      if (nxt > MAXP) nxt = MAXP;
      m_pending <= nxt;
      if (bus.flag_wr_en) m_status <= bus.flag_in;
    end
  end

  // Every-cycle comparison on the falling edge.
  always @(negedge clk) begin
    int ec, pa, ns;
    bit es;
    if (chk_en) begin
      model_eval(ec, es, ns, pa);
      check_val("cyc_check",   int'(bus.check),   ec);
      check_val("cyc_stall",   int'(bus.stall),   int'(es));
      check_val("cyc_status",  int'(bus.status),  int'(m_status));
      check_val("cyc_pending", int'(bus.pending), m_pending);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [3:0] c0, input logic [3:0] c1,
                       input logic [1:0] s, input logic we, input logic [3:0] fin,
                       input logic fl);
    bus.issue_valid      = v;
    bus.issue_cond       = {c1, c0};
    bus.issue_sets_flags = s;
    bus.flag_wr_en       = we;
    bus.flag_in          = fin;
    bus.flush            = fl;
  endtask

  task automatic idle();
    drive(2'b00, 4'h0, 4'h0, 2'b00, 1'b0, 4'h0, 1'b0);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst    = 1'b0;
    chk_en = 1'b1;

    // Reset state and plain evaluation on zero flags.
    drive(2'b01, 4'h0, 4'h0, 2'b00, 1'b0, 4'h0, 1'b0);
    #1 check_val("rst_eq_fails", int'(bus.check), 0);
    check_val("rst_status", int'(bus.status), 0);
    check_val("rst_pending", int'(bus.pending), 0);
    tick();
    drive(2'b01, 4'h1, 4'h0, 2'b00, 1'b0, 4'h0, 1'b0);
    #1 check_val("rst_ne_passes", int'(bus.check), 1);
    tick();

    // Setter accepted, dependent stalls, bypassed writeback releases it.
    drive(2'b01, 4'he, 4'h0, 2'b01, 1'b0, 4'h0, 1'b0);
    #1 check_val("set_no_stall", int'(bus.stall), 0);
    tick();
    check_val("set_pending1", int'(bus.pending), 1);
    drive(2'b01, 4'h0, 4'h0, 2'b00, 1'b0, 4'h0, 1'b0);
    #1 check_val("dep_stall", int'(bus.stall), 1);
    tick();
    drive(2'b01, 4'h0, 4'h0, 2'b00, 1'b1, 4'b0100, 1'b0);
    #1 check_val("byp_no_stall", int'(bus.stall), 0);
    check_val("byp_check", int'(bus.check), 1);
    tick();
    idle();
    #1 check_val("wb_status", int'(bus.status), 4);
    check_val("wb_pending", int'(bus.pending), 0);

    // Intra-group dependency.
    drive(2'b11, 4'he, 4'hb, 2'b01, 1'b0, 4'h0, 1'b0);
    #1 check_val("grp_stall", int'(bus.stall), 1);
    tick();
    check_val("grp_pend_hold", int'(bus.pending), 0);
    drive(2'b11, 4'he, 4'he, 2'b01, 1'b0, 4'h0, 1'b0);
    #1 check_val("grp_al_go", int'(bus.stall), 0);
    tick();
    check_val("grp_pend1", int'(bus.pending), 1);
    drive(2'b00, 4'h0, 4'h0, 2'b00, 1'b1, 4'h0, 1'b0);
    tick();
    drive(2'b11, 4'he, 4'he, 2'b11, 1'b0, 4'h0, 1'b0);
    tick();
    check_val("two_setters", int'(bus.pending), 2);

    // Flush with simultaneous writeback.
    drive(2'b01, 4'h0, 4'h0, 2'b00, 1'b1, 4'b1010, 1'b1);
    #1 check_val("flush_no_stall", int'(bus.stall), 0);
    tick();
    idle();
    #1 check_val("flush_pending", int'(bus.pending), 0);
    check_val("flush_status", int'(bus.status), 10);

    // All codes against all flag values via bypass (spurious writes, pending 0).
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        drive(2'b11, 4'(c), 4'(15 - c), 2'b00, 1'b1, 4'(f), 1'b0);
        #1;
        if (c == 9 && f == 6) check_val("ls_c1_z1", int'(bus.check[0]), 1);
        if (c == 15 && f == 0) begin
`ifdef COND_NV_EN
          check_val("nv_never", int'(bus.check[0]), 0);
`else
          check_val("nv_always", int'(bus.check[0]), 1);
`endif
        end
        tick();
      end
    end
    idle();
    #1 check_val("spur_status", int'(bus.status), 15);
    check_val("spur_pending", int'(bus.pending), 0);

    // Saturation at LANES*PIPE_DEPTH.
    drive(2'b11, 4'he, 4'he, 2'b11, 1'b0, 4'h0, 1'b0);
    tick();
    tick();
    check_val("sat_full", int'(bus.pending), MAXP);
    drive(2'b01, 4'he, 4'h0, 2'b01, 1'b0, 4'h0, 1'b0);
    tick();
    check_val("sat_hold", int'(bus.pending), MAXP);
    drive(2'b00, 4'h0, 4'h0, 2'b00, 1'b0, 4'h0, 1'b1);
    tick();

    // Randomized traffic, including occasional mid-run reset.
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(0, 59) == 0);
      drive(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            2'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 9) == 0));
      tick();
    end
    rst = 1'b0;
    idle();
    tick();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end
endmodule

// File: doc/cond_status_unit.md
# cond_status_unit

Parametrised condition-evaluation and status-register unit for the ID stage. Holds the architectural NZCV status register and evaluates the 4-bit condition field of up to `LANES` instructions per cycle. Tracks in-flight flag-setting instructions with a pending counter and raises `stall` whenever a conditional instruction would read stale flags. Flags written back from EXE in the current cycle are bypassed.

## Interface
Parameters:
- `LANES`, 1: instructions presented per cycle; lane 0 is oldest.
- `PIPE_DEPTH`, 2: maximum cycles from acceptance of a flag-setter to its `flag_wr_en`.
- `CW`, $clog2(LANES*PIPE_DEPTH+1): pending-counter width (derived).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: synchronous active-high reset.
- `flag_wr_en` in 1: EXE writes flags this cycle.
- `flag_in` in 4: new flags {N,Z,C,V}.
- `flush` in 1: pipeline flush; all in-flight flag-setters are killed.
- `issue_valid` in LANES: lane i holds an instruction.
- `issue_cond` in 4*LANES: condition field of lane i, bits [4i+3:4i].
- `issue_sets_flags` in LANES: lane i has the S bit set.
- `check` out LANES: lane i condition passes.
- `stall` out 1: issue group not accepted this cycle.
- `status` out 4: current status register {N,Z,C,V}.
- `pending` out CW: outstanding flag-setters.

## Operation
- Effective flags `eff` = `flag_in` when `flag_wr_en`, else `status`.
- Condition codes on `eff`: 0000 Z; 0001 ~Z; 0010 C; 0011 ~C; 0100 N; 0101 ~N; 0110 V; 0111 ~V; 1000 C&~Z; 1001 ~C|Z; 1010 N==V; 1011 N!=V; 1100 ~Z&(N==V); 1101 Z|(N!=V); 1110 1; 1111 per Configuration.
- `check[i]` is the evaluated condition, gated by `issue_valid[i]`; it is 0 when the lane is invalid.
- Lane i needs flags when valid and cond is not 1110.
- `pend_eff` = `pending` − (`flag_wr_en` && `pending`≠0).
- `stall` = OR over lanes of: lane i needs flags and (`pend_eff`≠0 or any valid lane j<i has `issue_sets_flags`). `flush` forces `stall`=0.
- Accepted setters = count of valid lanes with `issue_sets_flags` when `stall`=0 and `flush`=0; otherwise 0.
- Next `pending`: `flush` gives 0; otherwise `pend_eff` + accepted setters. The result saturates at LANES*PIPE_DEPTH.
- `flag_wr_en` with `pending`=0 (spurious write): `status` is still updated and the counter stays at 0.
- `status` loads `flag_in` on `flag_wr_en`, including in a `flush` cycle. It is unchanged otherwise.

## Timing
- `check` and `stall` are combinational from inputs, `status` and `pending`. Zero-cycle latency; bypass makes same-cycle writeback visible.
- `status` and `pending` update on the rising edge following the cycle that caused them.
- Reset values: `status`=4'b0000, `pending`=0. After reset `check` equals the combinational result on zero flags (e.g. cond 0001 passes), and `stall`=0 unless a lane sets flags ahead of a dependent lane.
- `rst` asserted mid-operation overrides `flag_wr_en`, `flush` and all issue activity in that cycle.
- A stalled group must be held stable by the upstream stage. The unit holds no copy of it.

## Configuration
- `COND_NV_EN` defined: cond 1111 evaluates to 0 (never) and needs flags for stall purposes like any non-AL code.
- `COND_NV_EN` undefined: cond 1111 evaluates to 1, identical to 1110, and never stalls.

## Test plan
- Reset, then LANES=1, cond 0000 and 0001 with no writes: `check`=0 then 1; `status`=0000, `pending`=0.
- Issue an S instruction (cond 1110), accepted so `pending`=1. Next cycle cond 0000 → `stall`=1. Following cycle `flag_wr_en`=1, `flag_in`=0100 → `stall`=0, `check`=1 via bypass; afterwards `status`=0100, `pending`=0.
- LANES=2: lane0 S-bit cond 1110, lane1 cond 1011 → `stall`=1, `pending` unchanged. Lane1 cond 1110 instead → `stall`=0, `pending`+1.
- `pending`=2 and `flush`=1 together with `flag_wr_en`=1, `flag_in`=1010 → next `pending`=0, `status`=1010, `stall`=0 during the flush cycle.
- Sweep all 16 codes × 16 flag values: `check` matches the Operation table, including 1001 with C=1,Z=1 → 1. Run with and without `COND_NV_EN` for code 1111.
- Spurious `flag_wr_en` with `pending`=0 → `status` updated, `pending` stays 0. Saturation: LANES*PIPE_DEPTH setters then one more → `pending` holds at max.
